// File: rtl/ac97_frame_tx_if.sv
// Codec register-write handshake between a command source and the AC'97 framer.
// The framer also reports back when a carried command has left the link.
interface ac97_frame_tx_if;
    logic        CMD_VALID;
    logic [6:0]  CMD_ADDR;
    logic [15:0] CMD_DATA;
    logic        CMD_READY;
    logic        CMD_SENT;

    modport master (
        output CMD_VALID,
        output CMD_ADDR,
        output CMD_DATA,
        input  CMD_READY,
        input  CMD_SENT
    );

    modport slave (
        input  CMD_VALID,
        input  CMD_ADDR,
        input  CMD_DATA,
        output CMD_READY,
        output CMD_SENT
    );
endinterface

// File: rtl/ac97_frame_tx.sv
// Outbound AC'97 framer: 256-bit frames carrying an optional codec register
// write in slots 1/2 and one mono sample duplicated into slots 3/4.
module ac97_frame_tx #(
    parameter int SAMPLE_W = 18
) (
    input  logic                BIT_CLK,
    input  logic                RESET_N,
    input  logic [SAMPLE_W-1:0] SAMPLE_IN,
    input  logic                PCM_EN,
    ac97_frame_tx_if.slave      cmd,
    output logic                SYNC,
    output logic                SDATA_OUT,
    output logic                frame_sig
);

    // Whole frame in MSB-first order; frame bit n sits at index 127-n, bits 96+ are zero.
    function automatic logic [127:0] build_frame(
        input logic        cv,
        input logic        pv,
        input logic [6:0]  addr,
        input logic [15:0] data,
        input logic [19:0] smp
    );
        logic [15:0] tag;
        logic [19:0] s1;
        logic [19:0] s2;
        logic [19:0] s3;
        tag = {cv | pv, cv, cv, pv, pv, 11'd0};
        s1  = cv ? {1'b0, addr, 12'd0} : 20'd0;
        s2  = cv ? {data, 4'd0} : 20'd0;
        s3  = pv ? smp : 20'd0;
        return {tag, s1, s2, s3, s3, 32'd0};
    endfunction

    logic [7:0]   bi_r;
    logic         pend_v_r;
    logic [6:0]   pend_addr_r;
    logic [15:0]  pend_data_r;
    logic         cmd_v_r;
    logic         pcm_v_r;
    logic [6:0]   frm_addr_r;
    logic [15:0]  frm_data_r;
    logic [19:0]  sample_r;
    logic         sync_r;
    logic         sdata_r;
    logic         frame_sig_r;
    logic         cmd_sent_r;
    logic         cmd_ready_r;

    logic [7:0]   bi_nxt_s;
    logic         boundary_s;
    logic         take_s;
    logic [19:0]  smp_pad_s;
    logic         pend_v_nxt_s;
    logic [6:0]   pend_addr_nxt_s;
    logic [15:0]  pend_data_nxt_s;
    logic         cmd_v_nxt_s;
    logic         pcm_v_nxt_s;
    logic [6:0]   frm_addr_nxt_s;
    logic [15:0]  frm_data_nxt_s;
    logic [19:0]  sample_nxt_s;
    logic [127:0] frame_vec_s;
    logic         sdata_nxt_s;

    // Bit index advance, boundary detect, handshake and left-justified sample.
    always_comb begin
        bi_nxt_s   = bi_r + 8'd1;
        boundary_s = (bi_r == 8'd255);
        take_s     = cmd.CMD_VALID & cmd_ready_r;
        smp_pad_s  = 20'd0;
        smp_pad_s[19 -: SAMPLE_W] = SAMPLE_IN;
    end

    // Pending buffer: a boundary transfer sees the pre-edge state, so a command
    // taken on the boundary edge itself waits for the following frame.
    always_comb begin
        pend_addr_nxt_s = pend_addr_r;
        pend_data_nxt_s = pend_data_r;
        if (take_s) begin
            pend_v_nxt_s    = 1'b1;
            pend_addr_nxt_s = cmd.CMD_ADDR;
            pend_data_nxt_s = cmd.CMD_DATA;
        end else if (boundary_s) begin
            pend_v_nxt_s = 1'b0;
        end else begin
            pend_v_nxt_s = pend_v_r;
        end
    end

    // Per-frame contents are frozen at the boundary for the whole frame.
    always_comb begin
        cmd_v_nxt_s    = cmd_v_r;
        pcm_v_nxt_s    = pcm_v_r;
        frm_addr_nxt_s = frm_addr_r;
        frm_data_nxt_s = frm_data_r;
        sample_nxt_s   = sample_r;
        if (boundary_s) begin
            cmd_v_nxt_s  = pend_v_r;
            pcm_v_nxt_s  = PCM_EN;
            sample_nxt_s = smp_pad_s;
            if (pend_v_r) begin
                frm_addr_nxt_s = pend_addr_r;
                frm_data_nxt_s = pend_data_r;
            end else begin
                frm_addr_nxt_s = frm_addr_r;
                frm_data_nxt_s = frm_data_r;
            end
        end else begin
            cmd_v_nxt_s = cmd_v_r;
        end
    end

    // Serial bit for the upcoming index, taken from the upcoming frame state so
    // the registered line matches the index it is driven under.
    always_comb begin
        frame_vec_s = build_frame(cmd_v_nxt_s, pcm_v_nxt_s, frm_addr_nxt_s,
                                  frm_data_nxt_s, sample_nxt_s);
        if (bi_nxt_s[7] == 1'b0) begin
            sdata_nxt_s = frame_vec_s[7'd127 - bi_nxt_s[6:0]];
        end else begin
            sdata_nxt_s = 1'b0;
        end
    end

    // Bit index, command buffers and frame content registers.
    always_ff @(posedge BIT_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bi_r        <= 8'd255;
            pend_v_r    <= 1'b0;
            pend_addr_r <= 7'd0;
            pend_data_r <= 16'd0;
            cmd_v_r     <= 1'b0;
            pcm_v_r     <= 1'b0;
            frm_addr_r  <= 7'd0;
            frm_data_r  <= 16'd0;
            sample_r    <= 20'd0;
        end else begin
            bi_r        <= bi_nxt_s;
            pend_v_r    <= pend_v_nxt_s;
            pend_addr_r <= pend_addr_nxt_s;
            pend_data_r <= pend_data_nxt_s;
            cmd_v_r     <= cmd_v_nxt_s;
            pcm_v_r     <= pcm_v_nxt_s;
            frm_addr_r  <= frm_addr_nxt_s;
            frm_data_r  <= frm_data_nxt_s;
            sample_r    <= sample_nxt_s;
        end
    end

    // Registered link and handshake outputs.
    always_ff @(posedge BIT_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_r      <= 1'b0;
            sdata_r     <= 1'b0;
            frame_sig_r <= 1'b0;
            cmd_sent_r  <= 1'b0;
            cmd_ready_r <= 1'b1;
        end else begin
            sync_r      <= (bi_nxt_s < 8'd16);
            sdata_r     <= sdata_nxt_s;
            frame_sig_r <= (bi_nxt_s == 8'd255);
            cmd_sent_r  <= (bi_nxt_s == 8'd56) && cmd_v_nxt_s;
            cmd_ready_r <= ~pend_v_nxt_s;
        end
    end

    assign SYNC          = sync_r;
    assign SDATA_OUT     = sdata_r;
    assign frame_sig     = frame_sig_r;
    assign cmd.CMD_SENT  = cmd_sent_r;
    assign cmd.CMD_READY = cmd_ready_r;

endmodule

// File: tb/tb_ac97_frame_tx.sv
// Directed bench for ac97_frame_tx: expected frames are queued per frame
// number and a negedge monitor reassembles each frame and compares it.
module tb_ac97_frame_tx;

    typedef struct {
        int          fnum;
        logic [15:0] tag;
        logic [19:0] s1;
        logic [19:0] s2;
        logic [19:0] s3;
        logic [19:0] s4;
    } frame_t;

    logic        BIT_CLK;
    logic        RESET_N;
    logic [17:0] SAMPLE_IN;
    logic        PCM_EN;
    logic        SYNC;
    logic        SDATA_OUT;
    logic        frame_sig;

    ac97_frame_tx_if cmd_if ();

    ac97_frame_tx #(.SAMPLE_W(18)) dut (
        .BIT_CLK   (BIT_CLK),
        .RESET_N   (RESET_N),
        .SAMPLE_IN (SAMPLE_IN),
        .PCM_EN    (PCM_EN),
        .cmd       (cmd_if),
        .SYNC      (SYNC),
        .SDATA_OUT (SDATA_OUT),
        .frame_sig (frame_sig)
    );

    int       total = 0;
    int       bad = 0;
    int       sent_cnt = 0;
    frame_t   exp_q[$];
    logic [7:0] tb_bi;
    int       fnum;
    logic     started;

    initial begin
        BIT_CLK = 1'b0;
        forever #5 BIT_CLK = ~BIT_CLK;
    end

    // Reference bit index and frame number, independent of the DUT.
    always @(posedge BIT_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tb_bi   <= 8'd255;
            fnum    <= -1;
            started <= 1'b0;
        end else begin
            tb_bi   <= tb_bi + 8'd1;
            if (tb_bi == 8'd255) fnum <= fnum + 1;
            started <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, expv);
        end
    endtask

    function automatic frame_t zero_frame();
        frame_t z;
        z.fnum = -1;
        z.tag = 16'h0000;
        z.s1 = 20'h00000;
        z.s2 = 20'h00000;
        z.s3 = 20'h00000;
        z.s4 = 20'h00000;
        return z;
    endfunction

    task automatic push_exp(input int fn, input logic [15:0] tg, input logic [19:0] a,
                            input logic [19:0] b, input logic [19:0] c, input logic [19:0] d);
        frame_t e;
        e.fnum = fn;
        e.tag = tg;
        e.s1 = a;
        e.s2 = b;
        e.s3 = c;
        e.s4 = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_bi(input int n);
        int k;
        k = 0;
        do begin
            @(negedge BIT_CLK);
            k++;
        end while (!(started && tb_bi == 8'(n)) && k < 1000);
        chk("wait_bi", {127'd0, (started && tb_bi == 8'(n))}, 128'd1);
    endtask

    // Monitor: per-cycle framing checks plus whole-frame comparison with the queue.
    initial begin
        frame_t      cur;
        logic [95:0] shreg;
        logic        tail;
        cur = zero_frame();
        shreg = '0;
        tail = 1'b0;
        forever begin
            @(negedge BIT_CLK);
            if (!RESET_N || !started) begin
                cur = zero_frame();
                shreg = '0;
                tail = 1'b0;
            end else begin
                if (tb_bi == 8'd0) begin
                    cur = zero_frame();
                    if (exp_q.size() > 0 && exp_q[0].fnum == fnum) cur = exp_q.pop_front();
                    shreg = '0;
                    tail = 1'b0;
                end
                chk("sync", SYNC, (tb_bi < 8'd16));
                chk("frame_sig", frame_sig, (tb_bi == 8'd255));
                chk("cmd_sent", cmd_if.CMD_SENT, (tb_bi == 8'd56) && cur.tag[14]);
                if (cmd_if.CMD_SENT === 1'b1) sent_cnt++;
                if (tb_bi < 8'd96) shreg = {shreg[94:0], SDATA_OUT};
                else tail = tail | SDATA_OUT;
                if (tb_bi == 8'd95) begin
                    chk("tag", shreg[95:80], cur.tag);
                    chk("slot1", shreg[79:60], cur.s1);
                    chk("slot2", shreg[59:40], cur.s2);
                    chk("slot3", shreg[39:20], cur.s3);
                    chk("slot4", shreg[19:0], cur.s4);
                end
                if (tb_bi == 8'd255) chk("tail_zero", tail, 1'b0);
            end
        end
    end

    initial begin
        int cyc;
        int f;
        int s0;
        RESET_N = 1'b0;
        PCM_EN = 1'b0;
        SAMPLE_IN = 18'h00000;
        cmd_if.CMD_VALID = 1'b0;
        cmd_if.CMD_ADDR = 7'h00;
        cmd_if.CMD_DATA = 16'h0000;
        repeat (3) @(negedge BIT_CLK);
        chk("rst_sync", SYNC, 1'b0);
        chk("rst_sdata", SDATA_OUT, 1'b0);
        chk("rst_fsig", frame_sig, 1'b0);
        chk("rst_sent", cmd_if.CMD_SENT, 1'b0);
        chk("rst_ready", cmd_if.CMD_READY, 1'b1);

        // Idle: first frame_sig 256 cycles after release.
        RESET_N = 1'b1;
        cyc = 0;
        do begin
            @(negedge BIT_CLK);
            cyc++;
        end while (frame_sig !== 1'b1 && cyc < 400);
        chk("first_fsig", cyc, 256);
        wait_bi(128);
        chk("idle_ready", cmd_if.CMD_READY, 1'b1);

        // Sample capture with a mid-frame input change.
        wait_bi(200);
        f = fnum;
        PCM_EN = 1'b1;
        SAMPLE_IN = 18'h3FFFF;
        push_exp(f + 1, 16'h9800, 20'h00000, 20'h00000, 20'hFFFFC, 20'hFFFFC);
        wait_bi(60);
        SAMPLE_IN = 18'h00000;
        PCM_EN = 1'b0;
        wait_bi(100);
        f = fnum;
        PCM_EN = 1'b1;
        SAMPLE_IN = 18'h2A5C3;
        push_exp(f + 1, 16'h9800, 20'h00000, 20'h00000, 20'hA970C, 20'hA970C);
        wait_bi(10);
        PCM_EN = 1'b0;

        // Single register write accepted at BI=100.
        wait_bi(100);
        f = fnum;
        chk("wr_ready_pre", cmd_if.CMD_READY, 1'b1);
        cmd_if.CMD_VALID = 1'b1;
        cmd_if.CMD_ADDR = 7'h02;
        cmd_if.CMD_DATA = 16'h0808;
        push_exp(f + 1, 16'hE000, 20'h02000, 20'h08080, 20'h00000, 20'h00000);
        @(negedge BIT_CLK);
        cmd_if.CMD_VALID = 1'b0;
        chk("wr_ready_low", cmd_if.CMD_READY, 1'b0);
        wait_bi(255);
        chk("wr_ready_255", cmd_if.CMD_READY, 1'b0);
        @(negedge BIT_CLK);
        chk("wr_ready_back", cmd_if.CMD_READY, 1'b1);
        wait_bi(100);

        // Back-to-back: A at BI=10, B held until the buffer frees.
        wait_bi(10);
        f = fnum;
        s0 = sent_cnt;
        cmd_if.CMD_VALID = 1'b1;
        cmd_if.CMD_ADDR = 7'h7F;
        cmd_if.CMD_DATA = 16'hFFFF;
        push_exp(f + 1, 16'hE000, 20'h7F000, 20'hFFFF0, 20'h00000, 20'h00000);
        @(negedge BIT_CLK);
        chk("b2b_ready_a", cmd_if.CMD_READY, 1'b0);
        cmd_if.CMD_ADDR = 7'h15;
        cmd_if.CMD_DATA = 16'hA5C3;
        wait_bi(0);
        chk("b2b_ready_free", cmd_if.CMD_READY, 1'b1);
        push_exp(f + 2, 16'hF800, 20'h15000, 20'hA5C30, 20'h00004, 20'h00004);
        @(negedge BIT_CLK);
        chk("b2b_ready_b", cmd_if.CMD_READY, 1'b0);
        cmd_if.CMD_VALID = 1'b0;
        PCM_EN = 1'b1;
        SAMPLE_IN = 18'h00001;
        wait_bi(100);
        chk("b2b_ready_mid", cmd_if.CMD_READY, 1'b0);
        wait_bi(100);
        PCM_EN = 1'b0;
        SAMPLE_IN = 18'h00000;
        wait_bi(200);
        chk("b2b_sent_cnt", sent_cnt - s0, 2);

        // Command offered exactly at BI=255.
        wait_bi(255);
        f = fnum;
        chk("b255_ready_pre", cmd_if.CMD_READY, 1'b1);
        cmd_if.CMD_VALID = 1'b1;
        cmd_if.CMD_ADDR = 7'h00;
        cmd_if.CMD_DATA = 16'h0001;
        push_exp(f + 2, 16'hE000, 20'h00000, 20'h00010, 20'h00000, 20'h00000);
        @(negedge BIT_CLK);
        cmd_if.CMD_VALID = 1'b0;
        chk("b255_ready_low", cmd_if.CMD_READY, 1'b0);
        wait_bi(255);
        chk("b255_ready_hold", cmd_if.CMD_READY, 1'b0);
        @(negedge BIT_CLK);
        chk("b255_ready_back", cmd_if.CMD_READY, 1'b1);
        wait_bi(100);
        chk("queue_drained", exp_q.size(), 0);

        // Reset in the middle of slot 3 with a command pending.
        wait_bi(200);
        PCM_EN = 1'b1;
        SAMPLE_IN = 18'h3FFFF;
        wait_bi(30);
        cmd_if.CMD_VALID = 1'b1;
        cmd_if.CMD_ADDR = 7'h33;
        cmd_if.CMD_DATA = 16'h1234;
        @(negedge BIT_CLK);
        cmd_if.CMD_VALID = 1'b0;
        chk("mr_pending", cmd_if.CMD_READY, 1'b0);
        wait_bi(70);
        chk("mr_sdata_pre", SDATA_OUT, 1'b1);
        s0 = sent_cnt;
        #2;
        RESET_N = 1'b0;
        #1;
        chk("mr_sdata", SDATA_OUT, 1'b0);
        chk("mr_sync", SYNC, 1'b0);
        chk("mr_ready", cmd_if.CMD_READY, 1'b1);
        PCM_EN = 1'b0;
        SAMPLE_IN = 18'h00000;
        repeat (2) @(negedge BIT_CLK);
        RESET_N = 1'b1;
        @(negedge BIT_CLK);
        chk("mr_restart_sync", SYNC, 1'b1);
        chk("mr_restart_bi0", {120'd0, tb_bi}, 128'd0);
        wait_bi(255);
        wait_bi(100);
        chk("mr_cmd_lost", sent_cnt - s0, 0);
        chk("mr_ready_after", cmd_if.CMD_READY, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
